sha_work_ctrl: RTL and testbench

SHA_WORK_CTRL -- requirements
Module: sha_work_ctrl

---
 rtl/sha_work_ctrl.sv | 145 ++++++++++++++
 tb/tb_sha_work_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_work_ctrl.sv
// Work-unit controller for a SHA miner core: loads a 19-word job, runs the miner, streams a 10-word result.
// Optional RUN-state watchdog enabled by defining SHA_WORK_TIMEOUT_EN.
module sha_work_ctrl #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [31:0]  m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last,
    output logic         miner_en,
    output logic [255:0] miner_prev_H,
    output logic [255:0] miner_prev_blk,
    output logic [95:0]  miner_input_M,
    input  logic [31:0]  miner_nonce,
    input  logic [255:0] miner_winner_H,
    input  logic         miner_done,
    input  logic         miner_found,
    output logic         busy
);

    typedef enum logic [1:0] {LOAD, RUN, SEND} state_t;

    state_t         state, next_state;
    logic [4:0]     cnt;
    logic           cap_found;
    logic           cap_timeout;
    logic [31:0]    cap_nonce;
    logic [255:0]   cap_h;
    logic           timeout_hit;

`ifdef SHA_WORK_TIMEOUT_EN
    logic [31:0] run_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            run_cnt <= '0;
        else if (state == RUN)
            run_cnt <= run_cnt + 32'd1;
        else
            run_cnt <= '0;
    end

    always_comb timeout_hit = (state == RUN) && (run_cnt == TIMEOUT_CYCLES - 32'd1);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    always_comb timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= LOAD;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD: if (s_valid && cnt == 5'd18) next_state = RUN;
            RUN:  if (miner_done || timeout_hit) next_state = SEND;
            SEND: if (m_ready && cnt == 5'd9) next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    // cnt is the job word index in LOAD and the result word index in SEND.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt            <= '0;
            miner_prev_H   <= '0;
            miner_prev_blk <= '0;
            miner_input_M  <= '0;
            cap_found      <= 1'b0;
            cap_timeout    <= 1'b0;
            cap_nonce      <= '0;
            cap_h          <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (s_valid) begin
                        for (int unsigned i = 0; i < 8; i++)
                            if (cnt == 5'(i)) miner_prev_H[(7 - i) * 32 +: 32] <= s_data;
                        for (int unsigned i = 8; i < 16; i++)
                            if (cnt == 5'(i)) miner_prev_blk[(15 - i) * 32 +: 32] <= s_data;
                        for (int unsigned i = 16; i < 19; i++)
                            if (cnt == 5'(i)) miner_input_M[(18 - i) * 32 +: 32] <= s_data;
                        cnt <= (cnt == 5'd18) ? '0 : cnt + 5'd1;
                    end
                end
                RUN: begin
                    // miner_done takes priority over a coincident watchdog expiry
                    if (miner_done) begin
                        cap_found   <= miner_found;
                        cap_timeout <= 1'b0;
                        cap_nonce   <= miner_nonce;
                        cap_h       <= miner_winner_H;
                        cnt         <= '0;
                    end else if (timeout_hit) begin
                        cap_found   <= 1'b0;
                        cap_timeout <= 1'b1;
                        cap_nonce   <= '0;
                        cap_h       <= '0;
                        cnt         <= '0;
                    end
                end
                SEND: begin
                    if (m_ready)
                        cnt <= (cnt == 5'd9) ? '0 : cnt + 5'd1;
                end
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        s_ready  = (state == LOAD);
        busy     = (state != LOAD);
        miner_en = (state == RUN);
        m_valid  = (state == SEND);
        m_last   = (state == SEND) && (cnt == 5'd9);
        m_data   = '0;
        if (state == SEND) begin
            case (cnt)
                5'd0: m_data = {30'b0, cap_timeout, cap_found};
                5'd1: m_data = cap_nonce;
                5'd2: m_data = cap_h[255:224];
                5'd3: m_data = cap_h[223:192];
                5'd4: m_data = cap_h[191:160];
                5'd5: m_data = cap_h[159:128];
                5'd6: m_data = cap_h[127:96];
                5'd7: m_data = cap_h[95:64];
                5'd8: m_data = cap_h[63:32];
                5'd9: m_data = cap_h[31:0];
                default: m_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_work_ctrl.sv
// Self-checking bench for sha_work_ctrl: transaction-level model checked every cycle plus directed literal checks.
// Define SHA_WORK_TIMEOUT_EN to also exercise the RUN watchdog with TIMEOUT_CYCLES=50.
module tb_sha_work_ctrl;

    localparam int TO = 50;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic         m_last;
    logic         miner_en;
    logic [255:0] miner_prev_H;
    logic [255:0] miner_prev_blk;
    logic [95:0]  miner_input_M;
    logic [31:0]  miner_nonce = '0;
    logic [255:0] miner_winner_H = '0;
    logic         miner_done = 1'b0;
    logic         miner_found = 1'b0;
    logic         busy;

    always #5 clk = ~clk;

    sha_work_ctrl #(.TIMEOUT_CYCLES(32'd50)) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .miner_en(miner_en), .miner_prev_H(miner_prev_H), .miner_prev_blk(miner_prev_blk),
        .miner_input_M(miner_input_M), .miner_nonce(miner_nonce), .miner_winner_H(miner_winner_H),
        .miner_done(miner_done), .miner_found(miner_found), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Model: phase 0 = loading, 1 = mining, 2 = sending; frame holds the words still to deliver.
    int           phase = 0;
    int           run_n = 0;
    logic [31:0]  mw[$];
    logic [31:0]  frame[$];
    logic [255:0] e_h = '0;
    logic [255:0] e_b = '0;
    logic [95:0]  e_m = '0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            phase = 0; run_n = 0; mw.delete(); frame.delete();
            e_h = '0; e_b = '0; e_m = '0;
        end else begin
            case (phase)
                0: if (s_valid) begin
                    mw.push_back(s_data);
                    if (mw.size() == 19) begin
                        for (int i = 0; i < 19; i++) begin
                            if (i < 8)       e_h = {e_h[223:0], mw[i]};
                            else if (i < 16) e_b = {e_b[223:0], mw[i]};
                            else             e_m = {e_m[63:0], mw[i]};
                        end
                        mw.delete();
                        phase = 1;
                        run_n = 0;
                    end
                end
                1: if (miner_done) begin
                    frame.delete();
                    frame.push_back({31'b0, miner_found});
                    frame.push_back(miner_nonce);
                    for (int k = 7; k >= 0; k--) frame.push_back(miner_winner_H[k*32 +: 32]);
                    phase = 2;
                end
`ifdef SHA_WORK_TIMEOUT_EN
                else begin
                    run_n++;
                    if (run_n == TO) begin
                        frame.delete();
                        frame.push_back(32'd2);
                        for (int k = 0; k < 9; k++) frame.push_back(32'd0);
                        phase = 2;
                    end
                end
`endif
                2: if (m_ready) begin
                    void'(frame.pop_front());
                    if (frame.size() == 0) phase = 0;
                end
                default: phase = 0;
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        check("ctrl", {s_ready, busy, miner_en, m_valid, m_last},
              {phase == 0, phase != 0, phase == 1, phase == 2, phase == 2 && frame.size() == 1});
        check("m_data", m_data, (phase == 2 && frame.size() > 0) ? frame[0] : 32'd0);
        if (phase != 0 || !reset) begin
            check("prev_H", miner_prev_H, e_h);
            check("prev_blk", miner_prev_blk, e_b);
            check("input_M", miner_input_M, e_m);
        end
    end

    logic [31:0] job_w[19];
    logic [31:0] rx_d[10];
    logic        rx_l[10];

    task automatic load_words(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && i % gap == gap - 1) begin
                s_valid = 1'b0;
                s_data  = 32'hDEADBEEF;
                @(posedge clk); #2;
            end
            s_data  = job_w[i];
            s_valid = 1'b1;
            @(posedge clk); #2;
        end
        s_valid = 1'b0;
    endtask

    task automatic receive(input bit toggle, output int n);
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            m_ready = toggle ? (c % 2 == 0) : 1'b1;
            s_valid = (c % 2 == 1);
            s_data  = 32'hBAD00000 + c;
            #2;
            if (m_valid && m_ready) begin
                rx_d[n] = m_data;
                rx_l[n] = m_last;
                n++;
            end
            @(posedge clk); #2;
        end
        m_ready = 1'b0;
        s_valid = 1'b0;
        check("rx_count", n, 10);
        check("ready_back", {s_ready, busy}, 2'b10);
    endtask

    task automatic finish_job(input bit found, input logic [31:0] nonce, input logic [255:0] h,
                              input bit toggle, output int n);
        repeat (3) begin @(posedge clk); #2; end
        miner_found = found; miner_nonce = nonce; miner_winner_H = h; miner_done = 1'b1;
        @(posedge clk); #2;
        miner_done = 1'b0; miner_found = 1'b1; miner_nonce = 32'hFFFFFFFF; miner_winner_H = '1;
        check("en_drop", miner_en, 1'b0);
        check("m_valid_rise", m_valid, 1'b1);
        // a late done pulse in SEND must not disturb the frame
        miner_done = 1'b1;
        @(posedge clk); #2;
        miner_done = 1'b0;
        receive(toggle, n);
    endtask

    initial begin
        int n;
        logic [255:0] h;
        logic [31:0]  exp_w[10];

        repeat (2) begin @(posedge clk); #2; end
        check("rst_ctrl", {s_ready, busy, miner_en, m_valid, m_last}, 5'b10000);
        check("rst_m_data", m_data, 32'd0);
        reset = 1'b1;
        @(posedge clk); #2;

        // done pulses while loading are ignored
        miner_done = 1'b1; miner_found = 1'b1;
        repeat (2) begin @(posedge clk); #2; end
        miner_done = 1'b0;
        check("done_in_load", {s_ready, busy, miner_en}, 3'b100);

        // job 1: words 1..19 back to back
        for (int i = 0; i < 19; i++) job_w[i] = i + 1;
        load_words(19, 0);
        check("j1_en", miner_en, 1'b1);
        check("j1_prevH_top", miner_prev_H[255:224], 32'h00000001);
        check("j1_M_low", miner_input_M[31:0], 32'h00000013);
        check("j1_blk_top", miner_prev_blk[255:224], 32'h00000009);
        finish_job(1'b1, 32'h1DAC2B7C, 256'hFF, 1'b0, n);
        exp_w[0] = 32'h00000001; exp_w[1] = 32'h1DAC2B7C;
        for (int i = 2; i < 9; i++) exp_w[i] = 32'h0;
        exp_w[9] = 32'h000000FF;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("j1_word%0d", i), rx_d[i], exp_w[i]);
            check($sformatf("j1_last%0d", i), rx_l[i], i == 9);
        end

        // job 2: gapped load, found=0, toggling m_ready
        for (int i = 0; i < 19; i++) job_w[i] = $urandom;
        load_words(19, 4);
        check("j2_blk_top", miner_prev_blk[255:224], job_w[8]);
        h = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        finish_job(1'b0, 32'h12345678, h, 1'b1, n);
        check("j2_word0", rx_d[0], 32'h0);
        check("j2_word1", rx_d[1], 32'h12345678);
        for (int k = 0; k < 8; k++) check($sformatf("j2_word%0d", k + 2), rx_d[k + 2], h[(7 - k)*32 +: 32]);
        for (int i = 0; i < 10; i++) check($sformatf("j2_last%0d", i), rx_l[i], i == 9);

        // reset after 7 words, asynchronously mid-cycle
        for (int i = 0; i < 19; i++) job_w[i] = 32'hA0000000 + i;
        load_words(7, 0);
        #1 reset = 1'b0;
        #1;
        check("arst_ctrl", {s_ready, busy, miner_en, m_valid, m_last}, 5'b10000);
        check("arst_prevH", miner_prev_H, 256'h0);
        check("arst_m_data", m_data, 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        load_words(19, 0);
        check("j3_prevH_top", miner_prev_H[255:224], 32'hA0000000);
        check("j3_blk_top", miner_prev_blk[255:224], 32'hA0000008);
        check("j3_M_low", miner_input_M[31:0], 32'hA0000012);
        check("j3_en", miner_en, 1'b1);

        // reset while running discards the job
        repeat (2) begin @(posedge clk); #2; end
        #1 reset = 1'b0;
        #1;
        check("rrst_ctrl", {s_ready, busy, miner_en}, 3'b100);
        check("rrst_M", miner_input_M, 96'h0);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        for (int i = 0; i < 19; i++) job_w[i] = 32'h5000 + i;
        load_words(19, 3);
        check("j4_prevH_top", miner_prev_H[255:224], 32'h00005000);
        finish_job(1'b1, 32'hCAFEF00D, {8{32'h13572468}}, 1'b1, n);
        check("j4_word1", rx_d[1], 32'hCAFEF00D);

`ifdef SHA_WORK_TIMEOUT_EN
        begin
            int n_en;
            n_en = 0;
            load_words(19, 0);
            for (int c = 0; c < 200 && miner_en; c++) begin
                n_en++;
                @(posedge clk); #2;
            end
            check("to_en_cycles", n_en, TO);
            receive(1'b0, n);
            check("to_word0", rx_d[0], 32'h00000002);
            for (int i = 1; i < 10; i++) check($sformatf("to_word%0d", i), rx_d[i], 32'h0);
        end
`endif

        repeat (2) begin @(posedge clk); #2; end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
